// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues in-order imem requests under a
// credit limit, buffers responses for decode and squashes wrong-path work on redirect.
module fetch_unit #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_src,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [31:0]     if_instr,
  output logic [XLEN-1:0] if_pc
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {BOOT, FETCH, FLUSH} state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [CW-1:0]   out_cnt;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   fifo_cnt;
  logic [AW-1:0]   fifo_rd;
  logic [AW-1:0]   fifo_wr;
  logic [AW-1:0]   pcq_rd;
  logic [AW-1:0]   pcq_wr;
  logic [31:0]     fifo_instr [FIFO_DEPTH];
  logic [XLEN-1:0] fifo_pc    [FIFO_DEPTH];
  logic [XLEN-1:0] pcq        [FIFO_DEPTH];

  logic            redirect;
  logic            credit_ok;
  logic            req_fire;
  logic            rsp_fire;
  logic            rsp_keep;
  logic            pop;
  logic [CW-1:0]   next_drop;

  // Requests are only issued while in-flight plus buffered stays below FIFO_DEPTH,
  // so every kept response is guaranteed a FIFO slot.
  assign redirect  = pc_src && (state != BOOT);
  assign credit_ok = ((CW+1)'(out_cnt) + (CW+1)'(fifo_cnt)) < (CW+1)'(FIFO_DEPTH);
  assign req_fire  = imem_req_valid && imem_req_ready;
  assign rsp_fire  = imem_rsp_valid && (out_cnt != '0);
  assign rsp_keep  = rsp_fire && (drop_cnt == '0);
  assign pop       = if_valid && if_ready;
  assign next_drop = out_cnt - CW'(rsp_fire);

  assign imem_req_valid = (state == FETCH) && !pc_src && credit_ok;
  assign imem_req_addr  = pc;
  assign if_valid       = (fifo_cnt != '0);
  assign if_instr       = fifo_instr[fifo_rd];
  assign if_pc          = fifo_pc[fifo_rd];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      out_cnt  <= '0;
      drop_cnt <= '0;
      fifo_cnt <= '0;
      fifo_rd  <= '0;
      fifo_wr  <= '0;
      pcq_rd   <= '0;
      pcq_wr   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_instr[i] <= '0;
        fifo_pc[i]    <= '0;
        pcq[i]        <= '0;
      end
    end else begin
      out_cnt <= out_cnt + CW'(req_fire) - CW'(rsp_fire);
      if (redirect) begin
        // Everything older than the branch is dead; responses still owed are counted off.
        pc       <= branch_target & ~XLEN'(3);
        fifo_cnt <= '0;
        fifo_rd  <= '0;
        fifo_wr  <= '0;
        pcq_rd   <= '0;
        pcq_wr   <= '0;
        drop_cnt <= next_drop;
        state    <= (next_drop != '0) ? FLUSH : FETCH;
      end else begin
        case (state)
          BOOT:    state <= FETCH;
          FLUSH:   if (drop_cnt == '0) state <= FETCH;
          default: state <= state;
        endcase
        if (req_fire) begin
          pc          <= pc + XLEN'(4);
          pcq[pcq_wr] <= pc;
          pcq_wr      <= pcq_wr + AW'(1);
        end
        if (rsp_fire && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
        if (rsp_keep) begin
          fifo_instr[fifo_wr] <= imem_rsp_data;
          fifo_pc[fifo_wr]    <= pcq[pcq_rd];
          fifo_wr             <= fifo_wr + AW'(1);
          pcq_rd              <= pcq_rd + AW'(1);
        end
        if (pop) fifo_rd <= fifo_rd + AW'(1);
        fifo_cnt <= fifo_cnt + CW'(rsp_keep) - CW'(pop);
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model with random latency, and a program-order
// reference (expected request PC and expected decode PC) that restarts on each redirect.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_src = 1'b0;
  logic [31:0] branch_target = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  fetch_unit dut (
    .clk(clk), .rst(rst), .pc_src(pc_src), .branch_target(branch_target),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int lat_lo = 1;
  int lat_hi = 1;
  int pops = 0;
  int accepts = 0;
  logic [31:0] mem_addr[$];
  int          mem_rdy[$];
  logic [31:0] exp_req_pc = '0;
  logic [31:0] exp_dec_pc = '0;
  logic        s_req_valid, s_if_valid, s_rsp;
  logic [31:0] s_req_addr, s_if_pc, s_if_instr;

  // Instruction word the memory returns for an address.
  function automatic logic [31:0] hw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input logic rdy, input logic ifr, input logic psrc, input logic [31:0] tgt);
    int lat;
    @(negedge clk);
    imem_req_ready = rdy;
    if_ready       = ifr;
    pc_src         = psrc;
    branch_target  = tgt;
    s_rsp          = (mem_addr.size() != 0) && (cyc >= mem_rdy[0]);
    imem_rsp_valid = s_rsp;
    imem_rsp_data  = s_rsp ? hw(mem_addr[0]) : $urandom;
    #1;
    s_req_valid = imem_req_valid;
    s_req_addr  = imem_req_addr;
    s_if_valid  = if_valid;
    s_if_pc     = if_pc;
    s_if_instr  = if_instr;
    if (s_req_valid) chk("req_addr", s_req_addr, exp_req_pc);
    if (psrc) chk("req_gated", 32'(s_req_valid), 32'd0);
    if (s_if_valid && ifr) begin
      chk("dec_pc", s_if_pc, exp_dec_pc);
      chk("dec_instr", s_if_instr, hw(exp_dec_pc));
      exp_dec_pc += 32'd4;
      pops++;
    end
    if (s_req_valid && rdy) begin
      lat = int'($urandom_range(lat_hi, lat_lo));
      mem_addr.push_back(s_req_addr);
      mem_rdy.push_back(cyc + lat);
      exp_req_pc += 32'd4;
      accepts++;
      chk("credit", 32'(mem_addr.size() <= 2), 32'd1);
    end
    if (s_rsp) begin
      void'(mem_addr.pop_front());
      void'(mem_rdy.pop_front());
    end
    if (psrc) begin
      exp_req_pc = tgt & ~32'd3;
      exp_dec_pc = tgt & ~32'd3;
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; pc_src = 1'b0; imem_req_ready = 1'b0; if_ready = 1'b0; imem_rsp_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_req_addr", imem_req_addr, 32'd0);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    rst = 1'b0;
    mem_addr.delete();
    mem_rdy.delete();
    exp_req_pc = '0;
    exp_dec_pc = '0;
    #1;
    chk("boot_no_req", 32'(imem_req_valid), 32'd0);
    @(posedge clk);
    cyc++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_req, first_v, acc0, p0, pending, n;
    logic found, prev;

    do_reset();

    // memory stalls: request held at the reset PC
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b0, '0);
      chk("stall_valid", 32'(s_req_valid), 32'd1);
      chk("stall_addr", s_req_addr, 32'd0);
    end

    // decode stalled: only FIFO_DEPTH requests accepted
    lat_lo = 1; lat_hi = 1;
    acc0 = accepts; first_req = -1; first_v = -1;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 1'b0, '0);
      if (s_req_valid && first_req < 0) first_req = i;
      if (s_if_valid && first_v < 0) first_v = i;
    end
    chk("bp_accepts", 32'(accepts - acc0), 32'd2);
    chk("ifv_latency", 32'(first_v - first_req), 32'd2);
    chk("bp_idle", 32'(s_req_valid), 32'd0);
    p0 = pops;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, '0);
    chk("drain_pops", 32'(pops - p0 >= 2), 32'd1);

    // redirect with 0x8 and 0xC in flight
    do_reset();
    lat_lo = 3; lat_hi = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mem_addr.size() == 2 && mem_addr[0] == 32'h8 && mem_addr[1] == 32'hC && cyc < mem_rdy[0])
        found = 1'b1;
      else
        step(1'b1, 1'b1, 1'b0, '0);
    end
    chk("flush_setup", 32'(found), 32'd1);
    step(1'b1, 1'b1, 1'b1, 32'h100);
    found = 1'b0; pending = -1;
    for (int i = 0; i < 20 && !found; i++) begin
      n = mem_addr.size();
      step(1'b1, 1'b0, 1'b0, '0);
      if (s_req_valid) begin found = 1'b1; pending = n; end
    end
    chk("flush_req_seen", 32'(found), 32'd1);
    chk("flush_first_addr", s_req_addr, 32'h100);
    chk("flush_drained", 32'(pending), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b1, 1'b1, 1'b0, '0);
      if (s_if_valid) found = 1'b1;
    end
    chk("flush_dec_seen", 32'(found), 32'd1);
    chk("flush_dec_pc", s_if_pc, 32'h100);

    // redirect with a response arriving in the same cycle and nothing else in flight
    lat_lo = 1; lat_hi = 1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mem_addr.size() == 1 && cyc >= mem_rdy[0]) found = 1'b1;
      else step(1'b1, 1'b1, 1'b0, '0);
    end
    chk("redir_setup", 32'(found), 32'd1);
    step(1'b1, 1'b1, 1'b1, 32'h203);
    step(1'b1, 1'b1, 1'b0, '0);
    chk("redir_valid", 32'(s_req_valid), 32'd1);
    chk("redir_addr", s_req_addr, 32'h200);
    chk("redir_no_stale", 32'(s_if_valid), 32'd0);

    // random traffic
    lat_lo = 1; lat_hi = 3;
    prev = 1'b0;
    p0 = pops;
    for (int i = 0; i < 1500; i++) begin
      logic ps;
      ps = !prev && ($urandom_range(15, 0) == 0);
      step(($urandom % 4) != 0, ($urandom % 3) != 0, ps, $urandom);
      prev = ps;
    end
    chk("liveness", 32'(pops - p0 > 100), 32'd1);

    // reset while work is outstanding and buffered
    lat_lo = 2; lat_hi = 2;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, '0);
    do_reset();
    step(1'b1, 1'b1, 1'b0, '0);
    chk("restart_valid", 32'(s_req_valid), 32'd1);
    chk("restart_addr", s_req_addr, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
